// File: rtl/full_st0_out_collect.sv
// rtl/full_st0_out_collect.sv - stage-0 result collector: burst tagging, FWFT FIFO, burst credit
module full_st0_out_collect #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          active,
  input  logic [DW-1:0] result_data,
  input  logic [2:0]    load_length,
  output logic [DW-1:0] stage_1_data,
  output logic          stage_1_data_fst,
  output logic          stage_1_data_vld,
  input  logic          stage_1_data_rdy,
  output logic          out_burst_rdy,
  output logic          burst_done,
  output logic [AW:0]   fill_level,
  output logic          overflow
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [DW:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     fill_q, fill_d;
  logic [2:0]      wc_q, wc_d;
  logic [2:0]      len_lat_q, len_lat_d;
  logic [DW-1:0]   head_data_q, head_data_d;
  logic            head_fst_q, head_fst_d;
  logic            vld_q, vld_d;
  logic            burst_done_q, burst_done_d;
  logic            overflow_q, overflow_d;

  logic            push, pop, fst_in, last_word;
  logic [2:0]      cur_len;
  logic [AW:0]     free_cnt, need_cnt;

  always_comb begin
    pop       = vld_q & stage_1_data_rdy;
    push      = active & ((fill_q < DEPTH_L) | pop);
    fst_in    = (wc_q == 3'd0);
    // The first word of a burst uses the live length; later words use the latched one.
    cur_len   = fst_in ? load_length : len_lat_q;
    last_word = (wc_q == cur_len);
  end

  always_comb begin
    wc_d         = wc_q;
    len_lat_d    = len_lat_q;
    burst_done_d = active & last_word;
    overflow_d   = overflow_q | (active & ~push);
    if (active) begin
      if (fst_in) len_lat_d = load_length;
      wc_d = last_word ? 3'd0 : wc_q + 3'd1;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    fill_d   = fill_q;
    if (push && !pop)      fill_d = fill_q + (AW+1)'(1);
    else if (pop && !push) fill_d = fill_q - (AW+1)'(1);
    vld_d       = (fill_d != '0);
    head_data_d = head_data_q;
    head_fst_d  = head_fst_q;
    // Next head is either the word being written this cycle (empty or draining to it) or stored.
    if (fill_d != '0) begin
      if (push && (wr_ptr_q == rd_ptr_d)) begin
        head_fst_d  = fst_in;
        head_data_d = result_data;
      end else begin
        {head_fst_d, head_data_d} = mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {fst_in, result_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fill_q       <= '0;
      wc_q         <= 3'd0;
      len_lat_q    <= 3'd0;
      head_data_q  <= '0;
      head_fst_q   <= 1'b0;
      vld_q        <= 1'b0;
      burst_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fill_q       <= fill_d;
      wc_q         <= wc_d;
      len_lat_q    <= len_lat_d;
      head_data_q  <= head_data_d;
      head_fst_q   <= head_fst_d;
      vld_q        <= vld_d;
      burst_done_q <= burst_done_d;
      overflow_q   <= overflow_d;
    end
  end

  always_comb begin
    free_cnt = DEPTH_L - fill_q;
    need_cnt = (AW+1)'(load_length) + (AW+1)'(1);
  end

  assign stage_1_data     = head_data_q;
  assign stage_1_data_fst = head_fst_q;
  assign stage_1_data_vld = vld_q;
  assign out_burst_rdy    = (free_cnt >= need_cnt);
  assign burst_done       = burst_done_q;
  assign fill_level       = fill_q;
  assign overflow         = overflow_q;

endmodule

// File: tb/tb_full_st0_out_collect.sv
// tb/tb_full_st0_out_collect.sv - randomized bench with queue-based reference model
module tb_full_st0_out_collect;

  logic        clk = 1'b0;
  logic        reset;
  logic        active;
  logic [31:0] result_data;
  logic [2:0]  load_length;
  logic [31:0] stage_1_data;
  logic        stage_1_data_fst;
  logic        stage_1_data_vld;
  logic        stage_1_data_rdy;
  logic        out_burst_rdy;
  logic        burst_done;
  logic [4:0]  fill_level;
  logic        overflow;

  int n_cmp = 0;
  int n_mis = 0;

  // reference model: queue of {fst, data}, words left in current burst
  logic [32:0] mq[$];
  int          m_rem;
  bit          m_ovf, m_bd;

  always #5 clk = ~clk;

  full_st0_out_collect dut (
    .clk(clk), .reset(reset), .active(active), .result_data(result_data),
    .load_length(load_length), .stage_1_data(stage_1_data),
    .stage_1_data_fst(stage_1_data_fst), .stage_1_data_vld(stage_1_data_vld),
    .stage_1_data_rdy(stage_1_data_rdy), .out_burst_rdy(out_burst_rdy),
    .burst_done(burst_done), .fill_level(fill_level), .overflow(overflow)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    bit pop, push, fst;
    if (reset) begin
      mq.delete();
      m_rem = 0;
      m_ovf = 0;
      m_bd  = 0;
    end else begin
      pop  = (mq.size() != 0) && stage_1_data_rdy;
      push = active && ((mq.size() < 16) || pop);
      fst  = 0;
      m_bd = 0;
      if (active) begin
        if (m_rem == 0) begin
          fst   = 1;
          m_rem = int'(load_length) + 1;
        end
        m_rem--;
        m_bd = (m_rem == 0);
        if (!push) m_ovf = 1;
      end
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back({fst, result_data});
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_eq("vld", stage_1_data_vld, mq.size() != 0);
    if (mq.size() != 0) begin
      check_eq("data", stage_1_data, mq[0][31:0]);
      check_eq("fst", stage_1_data_fst, mq[0][32]);
    end
    check_eq("fill", fill_level, mq.size());
    check_eq("burst_rdy", out_burst_rdy, (16 - mq.size()) >= (int'(load_length) + 1));
    check_eq("burst_done", burst_done, m_bd);
    check_eq("overflow", overflow, m_ovf);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit rst, input bit act, input logic [31:0] d,
                       input logic [2:0] len, input bit rdy);
    reset = rst; active = act; result_data = d; load_length = len; stage_1_data_rdy = rdy;
    tick();
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && mq.size() > 0; i++) drive(0, 0, 32'h0, 3'd7, 1);
    drive(0, 0, 32'h0, 3'd7, 1);
    check_eq("drained", fill_level, 0);
  endtask

  initial begin
    int sent, burst_left, cyc;
    reset = 1; active = 0; result_data = '0; load_length = 3'd0; stage_1_data_rdy = 0;
    m_rem = 0; m_ovf = 0; m_bd = 0;
    drive(1, 0, 32'h0, 3'd3, 1);
    drive(1, 0, 32'h0, 3'd3, 1);
    @(negedge clk);
    check_eq("rst_data", stage_1_data, 0);
    check_eq("rst_fst", stage_1_data_fst, 0);
    check_eq("rst_burst_rdy", out_burst_rdy, 1);
    @(posedge clk); #1;

    // single burst of 4, downstream always ready
    for (int i = 0; i < 4; i++) drive(0, 1, 32'h10 + i, 3'd3, 1);
    drain();

    // two bursts of 8 into a stalled FIFO, then one word too many
    for (int i = 0; i < 16; i++) drive(0, 1, 32'h100 + i, 3'd7, 0);
    drive(0, 0, 32'h0, 3'd7, 0);
    check_eq("full_fill", fill_level, 16);
    check_eq("full_burst_rdy", out_burst_rdy, 0);
    drive(0, 1, 32'hdead, 3'd7, 0);
    drive(0, 0, 32'h0, 3'd7, 0);
    check_eq("ovf_set", overflow, 1);
    drain();
    drive(1, 0, 32'h0, 3'd7, 0);

    // full FIFO with simultaneous write and read
    for (int i = 0; i < 16; i++) drive(0, 1, 32'h200 + i, 3'd7, 0);
    drive(0, 1, 32'h300, 3'd7, 1);
    drive(0, 0, 32'h0, 3'd7, 0);
    check_eq("full_pushpop_fill", fill_level, 16);
    check_eq("full_pushpop_ovf", overflow, 0);
    drain();

    // length change mid-burst only affects the next burst
    drive(0, 1, 32'h400, 3'd3, 1);
    drive(0, 1, 32'h401, 3'd1, 1);
    drive(0, 1, 32'h402, 3'd1, 1);
    drive(0, 1, 32'h403, 3'd1, 1);
    drive(0, 1, 32'h404, 3'd1, 1);
    drive(0, 1, 32'h405, 3'd1, 1);
    drain();

    // reset in the middle of a partial burst
    for (int i = 0; i < 5; i++) drive(0, 1, 32'h500 + i, 3'd7, 0);
    drive(1, 0, 32'h0, 3'd7, 0);
    drive(0, 0, 32'h0, 3'd7, 0);
    check_eq("mid_rst_vld", stage_1_data_vld, 0);
    check_eq("mid_rst_fill", fill_level, 0);
    drive(0, 1, 32'h600, 3'd7, 0);
    drive(0, 0, 32'h0, 3'd7, 0);
    check_eq("mid_rst_fst", stage_1_data_fst, 1);
    drive(1, 0, 32'h0, 3'd5, 0);

    // random ready, bursts of 6 started only when credit allows
    sent = 0; burst_left = 0; cyc = 0;
    while (sent < 200 && cyc < 3000) begin
      cyc++;
      if (burst_left == 0 && (16 - mq.size()) >= 6 && $urandom_range(0, 3) != 0)
        burst_left = 6;
      if (burst_left > 0) begin
        drive(0, 1, $urandom, 3'd5, bit'($urandom_range(0, 1)));
        burst_left--;
        sent++;
      end else begin
        drive(0, 0, $urandom, 3'd5, bit'($urandom_range(0, 1)));
      end
    end
    check_eq("rand_budget", cyc < 3000, 1);
    while (burst_left > 0) begin
      drive(0, 1, $urandom, 3'd5, bit'($urandom_range(0, 1)));
      burst_left--;
    end
    drain();
    check_eq("rand_ovf", overflow, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
